// File: rtl/bip_control_unit_if.sv
// ---------------------------------------------------------------------------
// bip_control_unit_if
// Purpose : bundles the run request, program-memory and datapath-control
//           signals of the BIP control unit into one connection.
// Signals : i_start      run request from the debug/host side
//           i_instr      program-memory read data (one cycle after o_pc)
//           o_pc         program-memory address
//           o_addr       data-RAM address taken from the instruction
//           o_operand    sign-extended immediate from the instruction
//           o_sel_a      accumulator input mux select
//           o_sel_b      ALU B operand select
//           o_op         ALU operation (0 add, 1 subtract)
//           o_en_acc     accumulator load enable
//           o_rd_ram     data-RAM read strobe
//           o_wr_ram     data-RAM write strobe
//           o_busy       instruction in flight
//           o_halt       halted on HLT
//           o_icount     retired-instruction counter (saturating)
// Modports: master = control unit, slave = datapath / memories / host.
// ---------------------------------------------------------------------------
interface bip_control_unit_if #(
  parameter int PC_BITS = 11,
  parameter int E_BITS  = 16
) ();
  logic                i_start;
  logic [E_BITS-1:0]   i_instr;
  logic [PC_BITS-1:0]  o_pc;
  logic [PC_BITS-1:0]  o_addr;
  logic [E_BITS-1:0]   o_operand;
  logic [1:0]          o_sel_a;
  logic                o_sel_b;
  logic                o_op;
  logic                o_en_acc;
  logic                o_rd_ram;
  logic                o_wr_ram;
  logic                o_busy;
  logic                o_halt;
  logic [15:0]         o_icount;

  modport master (
    input  i_start, i_instr,
    output o_pc, o_addr, o_operand, o_sel_a, o_sel_b, o_op,
           o_en_acc, o_rd_ram, o_wr_ram, o_busy, o_halt, o_icount
  );

  modport slave (
    output i_start, i_instr,
    input  o_pc, o_addr, o_operand, o_sel_a, o_sel_b, o_op,
           o_en_acc, o_rd_ram, o_wr_ram, o_busy, o_halt, o_icount
  );
endinterface

// File: rtl/bip_control_unit.sv
// ---------------------------------------------------------------------------
// bip_control_unit
// Purpose : multi-cycle control unit for the 16-bit BIP accumulator
//           datapath. Fetches from a synchronous program memory, decodes
//           and issues accumulator/ALU/data-RAM controls, keeps the PC and
//           a saturating retired-instruction counter.
// Ports   : i_clock  system clock, rising edge
//           i_reset  synchronous active-high reset
//           bus      bip_control_unit_if.master (start, instruction fetch,
//                    datapath controls, status)
// Cycle   : FETCH -> LOAD -> READ -> EXEC per instruction (4 cycles);
//           HLT stops after LOAD and parks in HALT until i_start.
// ---------------------------------------------------------------------------
module bip_control_unit #(
  parameter int PC_BITS  = 11,
  parameter int E_BITS   = 16,
  parameter int OPC_BITS = 5
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  bip_control_unit_if.master    bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_READ  = 3'd3;
  localparam logic [2:0] ST_EXEC  = 3'd4;
  localparam logic [2:0] ST_HALT  = 3'd5;

  localparam logic [OPC_BITS-1:0] OPC_HLT  = 5'b00000;
  localparam logic [OPC_BITS-1:0] OPC_STO  = 5'b00001;
  localparam logic [OPC_BITS-1:0] OPC_LD   = 5'b00010;
  localparam logic [OPC_BITS-1:0] OPC_LDI  = 5'b00011;
  localparam logic [OPC_BITS-1:0] OPC_ADD  = 5'b00100;
  localparam logic [OPC_BITS-1:0] OPC_ADDI = 5'b00101;
  localparam logic [OPC_BITS-1:0] OPC_SUB  = 5'b00110;
  localparam logic [OPC_BITS-1:0] OPC_SUBI = 5'b00111;

  logic [2:0]          r_state;
  logic [PC_BITS-1:0]  r_pc;
  logic [E_BITS-1:0]   r_ir;
  logic [15:0]         r_icount;

  logic [OPC_BITS-1:0] w_opc;
  logic [OPC_BITS-1:0] w_fetch_opc;
  logic [1:0]          w_sel_a;
  logic                w_sel_b;
  logic                w_op;
  logic                w_en_acc;
  logic                w_rd_ram;
  logic                w_wr_ram;

  assign w_opc       = r_ir[E_BITS-1 -: OPC_BITS];
  assign w_fetch_opc = bus.i_instr[E_BITS-1 -: OPC_BITS];

  // ---------------------------------------------------------------------
  // Sequencer, PC, IR and retired-instruction counter
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_pc     <= '0;
      r_ir     <= '0;
      r_icount <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_HALT: begin
          // A new run always begins at address 0 with a fresh count;
          // IR keeps its last value so o_addr/o_operand stay stable.
          if (bus.i_start) begin
            r_state  <= ST_FETCH;
            r_pc     <= '0;
            r_icount <= '0;
          end
        end
        ST_FETCH: r_state <= ST_LOAD;
        ST_LOAD: begin
          r_ir    <= bus.i_instr;
          // HLT is recognised straight from the memory word so it never
          // reaches READ/EXEC and is neither counted nor advances PC.
          r_state <= (w_fetch_opc == OPC_HLT) ? ST_HALT : ST_READ;
        end
        ST_READ: r_state <= ST_EXEC;
        ST_EXEC: begin
          r_pc    <= r_pc + 1'b1;
          if (r_icount != 16'hFFFF) begin
            r_icount <= r_icount + 16'd1;
          end
          r_state <= ST_FETCH;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Moore decode: strobes depend only on state and IR
  // ---------------------------------------------------------------------
  always_comb begin
    w_sel_a  = 2'b00;
    w_sel_b  = 1'b0;
    w_op     = 1'b0;
    w_en_acc = 1'b0;
    w_rd_ram = 1'b0;
    w_wr_ram = 1'b0;
    if (r_state == ST_READ) begin
      // Only instructions that consume a RAM operand read it.
      w_rd_ram = (w_opc == OPC_LD) || (w_opc == OPC_ADD) || (w_opc == OPC_SUB);
    end else if (r_state == ST_EXEC) begin
      case (w_opc)
        OPC_STO:  w_wr_ram = 1'b1;
        OPC_LD:   begin w_sel_a = 2'b00; w_en_acc = 1'b1; end
        OPC_LDI:  begin w_sel_a = 2'b01; w_en_acc = 1'b1; end
        OPC_ADD:  begin w_sel_a = 2'b10; w_sel_b = 1'b0; w_op = 1'b0; w_en_acc = 1'b1; end
        OPC_ADDI: begin w_sel_a = 2'b10; w_sel_b = 1'b1; w_op = 1'b0; w_en_acc = 1'b1; end
        OPC_SUB:  begin w_sel_a = 2'b10; w_sel_b = 1'b0; w_op = 1'b1; w_en_acc = 1'b1; end
        OPC_SUBI: begin w_sel_a = 2'b10; w_sel_b = 1'b1; w_op = 1'b1; w_en_acc = 1'b1; end
        default:  ; // remaining opcodes execute as NOP
      endcase
    end
  end

  assign bus.o_pc      = r_pc;
  assign bus.o_addr    = r_ir[PC_BITS-1:0];
  assign bus.o_operand = {{(E_BITS-PC_BITS){r_ir[PC_BITS-1]}}, r_ir[PC_BITS-1:0]};
  assign bus.o_sel_a   = w_sel_a;
  assign bus.o_sel_b   = w_sel_b;
  assign bus.o_op      = w_op;
  assign bus.o_en_acc  = w_en_acc;
  assign bus.o_rd_ram  = w_rd_ram;
  assign bus.o_wr_ram  = w_wr_ram;
  assign bus.o_busy    = (r_state == ST_FETCH) || (r_state == ST_LOAD) ||
                         (r_state == ST_READ)  || (r_state == ST_EXEC);
  assign bus.o_halt    = (r_state == ST_HALT);
  assign bus.o_icount  = r_icount;

endmodule

// File: tb/tb_bip_control_unit.sv
// ---------------------------------------------------------------------------
// tb_bip_control_unit
// Instruction-level model expands each executed instruction into the cycles
// it must occupy; a negedge process compares every model cycle against the
// DUT. Directed literal checks pin key cycles of each program.
// ---------------------------------------------------------------------------
module tb_bip_control_unit;

  logic clk;
  logic rst;

  bip_control_unit_if #(.PC_BITS(11), .E_BITS(16)) bus ();

  bip_control_unit #(.PC_BITS(11), .E_BITS(16), .OPC_BITS(5)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous program memory
  logic [15:0] prog [0:2047];
  always @(posedge clk) bus.i_instr <= prog[bus.o_pc];

  typedef struct packed {
    logic [10:0] pc;
    logic [10:0] addr;
    logic [15:0] operand;
    logic [1:0]  sel_a;
    logic        sel_b;
    logic        op;
    logic        en;
    logic        rd;
    logic        wr;
    logic        busy;
    logic        halt;
    logic [15:0] icount;
  } rec_t;

  rec_t        exp_q[$];
  rec_t        cmp_e;
  logic [15:0] seq_q[$];
  logic [15:0] m_ir;
  int          m_pc;
  int          m_cnt;
  int          n_vec = 0;
  int          n_err = 0;
  int          cur   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected record for a cycle with no strobes, from the model state.
  function automatic rec_t base_rec(input bit busy, input bit halt);
    rec_t r;
    int   v;
    r = '0;
    v = int'(m_ir[10:0]);
    if (v >= 1024) v = v - 2048;
    r.pc     = 11'(m_pc);
    r.addr   = m_ir[10:0];
    r.operand = 16'(v);
    r.busy   = busy;
    r.halt   = halt;
    r.icount = 16'(m_cnt);
    return r;
  endfunction

  // Expand the fetched instruction sequence into per-cycle expectations.
  task automatic build_expected();
    rec_t r;
    int   opc;
    m_pc  = 0;
    m_cnt = 0;
    foreach (seq_q[k]) begin
      exp_q.push_back(base_rec(1'b1, 1'b0));   // FETCH
      exp_q.push_back(base_rec(1'b1, 1'b0));   // LOAD
      m_ir = seq_q[k];
      opc  = int'(m_ir[15:11]);
      if (opc == 0) break;
      r = base_rec(1'b1, 1'b0);                // READ
      r.rd = (opc == 2) || (opc == 4) || (opc == 6);
      exp_q.push_back(r);
      r = base_rec(1'b1, 1'b0);                // EXEC
      case (opc)
        1: r.wr = 1'b1;
        2: begin r.en = 1'b1; r.sel_a = 2'd0; end
        3: begin r.en = 1'b1; r.sel_a = 2'd1; end
        4, 5, 6, 7: begin
          r.en    = 1'b1;
          r.sel_a = 2'd2;
          r.sel_b = (opc == 5) || (opc == 7);
          r.op    = (opc >= 6);
        end
        default: ;
      endcase
      exp_q.push_back(r);
      m_pc  = (m_pc + 1) % 2048;
      m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
    end
    repeat (3) exp_q.push_back(base_rec(1'b0, 1'b1));
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cmp_e = exp_q.pop_front();
      chk("pc",      32'(bus.o_pc),      32'(cmp_e.pc));
      chk("addr",    32'(bus.o_addr),    32'(cmp_e.addr));
      chk("operand", 32'(bus.o_operand), 32'(cmp_e.operand));
      chk("sel_a",   32'(bus.o_sel_a),   32'(cmp_e.sel_a));
      chk("sel_b",   32'(bus.o_sel_b),   32'(cmp_e.sel_b));
      chk("op",      32'(bus.o_op),      32'(cmp_e.op));
      chk("en_acc",  32'(bus.o_en_acc),  32'(cmp_e.en));
      chk("rd_ram",  32'(bus.o_rd_ram),  32'(cmp_e.rd));
      chk("wr_ram",  32'(bus.o_wr_ram),  32'(cmp_e.wr));
      chk("busy",    32'(bus.o_busy),    32'(cmp_e.busy));
      chk("halt",    32'(bus.o_halt),    32'(cmp_e.halt));
      chk("icount",  32'(bus.o_icount),  32'(cmp_e.icount));
    end
  end

  // Pulse i_start; afterwards the bench sits at the negedge of cycle 1.
  task automatic start_run(input string name, input bit use_model);
    @(posedge clk); #1 bus.i_start = 1'b1;
    @(posedge clk); #1 bus.i_start = 1'b0;
    if (use_model) build_expected();
    $display("run %s: %0d instructions, %0d model cycles", name, seq_q.size(), exp_q.size());
    @(negedge clk);
    cur = 1;
  endtask

  task automatic goto(input int n);
    while (cur < n) begin
      @(negedge clk);
      cur++;
    end
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (exp_q.size() > 0 && b < 20000) begin
      @(negedge clk);
      b++;
    end
    if (exp_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d pending cycles expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2048; i++) prog[i] = 16'h0000;
    m_ir        = 16'h0000;
    rst         = 1'b1;
    bus.i_start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pc",     32'(bus.o_pc),     32'd0);
    chk("rst_busy",   32'(bus.o_busy),   32'd0);
    chk("rst_halt",   32'(bus.o_halt),   32'd0);
    chk("rst_en",     32'(bus.o_en_acc), 32'd0);
    chk("rst_wr",     32'(bus.o_wr_ram), 32'd0);
    chk("rst_sel_a",  32'(bus.o_sel_a),  32'd0);
    chk("rst_icount", 32'(bus.o_icount), 32'd0);
    chk("rst_addr",   32'(bus.o_addr),   32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // LDI 5, ADDI 3, STO 7, HLT
    prog[0] = 16'h1805; prog[1] = 16'h2803; prog[2] = 16'h0807; prog[3] = 16'h0000;
    seq_q = '{16'h1805, 16'h2803, 16'h0807, 16'h0000};
    start_run("ldi_addi_sto", 1'b1);
    goto(4);  chk("t1_en_c4", 32'(bus.o_en_acc), 32'd1); chk("t1_sela_c4", 32'(bus.o_sel_a), 32'd1);
    goto(8);  chk("t1_en_c8", 32'(bus.o_en_acc), 32'd1); chk("t1_sela_c8", 32'(bus.o_sel_a), 32'd2);
              chk("t1_selb_c8", 32'(bus.o_sel_b), 32'd1);
    goto(12); chk("t1_wr_c12", 32'(bus.o_wr_ram), 32'd1); chk("t1_addr_c12", 32'(bus.o_addr), 32'd7);
    goto(13); chk("t1_pc_c13", 32'(bus.o_pc), 32'd3);
    goto(14); chk("t1_halt_c14", 32'(bus.o_halt), 32'd0);
    goto(15); chk("t1_halt_c15", 32'(bus.o_halt), 32'd1);
    drain();
    chk("t1_pc_end", 32'(bus.o_pc), 32'd3);
    chk("t1_icount_end", 32'(bus.o_icount), 32'd3);

    // LD 0x010, HLT
    prog[0] = 16'h1010; prog[1] = 16'h0000;
    seq_q = '{16'h1010, 16'h0000};
    start_run("ld", 1'b1);
    goto(3); chk("t2_rd_read", 32'(bus.o_rd_ram), 32'd1); chk("t2_addr", 32'(bus.o_addr), 32'h010);
    goto(4); chk("t2_rd_exec", 32'(bus.o_rd_ram), 32'd0); chk("t2_en", 32'(bus.o_en_acc), 32'd1);
             chk("t2_sela", 32'(bus.o_sel_a), 32'd0);
    drain();

    // SUBI 0x7FF, HLT
    prog[0] = 16'h3FFF; prog[1] = 16'h0000;
    seq_q = '{16'h3FFF, 16'h0000};
    start_run("subi", 1'b1);
    goto(4); chk("t3_operand", 32'(bus.o_operand), 32'hFFFF); chk("t3_op", 32'(bus.o_op), 32'd1);
             chk("t3_selb", 32'(bus.o_sel_b), 32'd1); chk("t3_sela", 32'(bus.o_sel_a), 32'd2);
             chk("t3_en", 32'(bus.o_en_acc), 32'd1);
    goto(5); chk("t3_en_after", 32'(bus.o_en_acc), 32'd0);
    drain();

    // Opcode 11111 then HLT, i_start held through the whole instruction
    prog[0] = 16'hF923; prog[1] = 16'h0000;
    seq_q = '{16'hF923, 16'h0000};
    start_run("nop_start_busy", 1'b1);
    bus.i_start = 1'b1;
    goto(5);
    bus.i_start = 1'b0;
    chk("t4_pc_hlt_fetch", 32'(bus.o_pc), 32'd1);
    drain();
    chk("t4_icount", 32'(bus.o_icount), 32'd1);

    // Reset during READ of STO 0x005
    prog[0] = 16'h1801; prog[1] = 16'h0805; prog[2] = 16'h0000;
    seq_q = '{16'h1801, 16'h0805, 16'h0000};
    start_run("reset_mid", 1'b0);
    goto(7); chk("t5_busy", 32'(bus.o_busy), 32'd1); chk("t5_addr", 32'(bus.o_addr), 32'd5);
             chk("t5_pc", 32'(bus.o_pc), 32'd1); chk("t5_icount", 32'(bus.o_icount), 32'd1);
    rst = 1'b1;
    goto(8); chk("t5_busy_rst", 32'(bus.o_busy), 32'd0); chk("t5_pc_rst", 32'(bus.o_pc), 32'd0);
             chk("t5_icount_rst", 32'(bus.o_icount), 32'd0); chk("t5_addr_rst", 32'(bus.o_addr), 32'd0);
             chk("t5_halt_rst", 32'(bus.o_halt), 32'd0);
    rst  = 1'b0;
    m_ir = 16'h0000;
    for (int c = 9; c <= 16; c++) begin
      goto(c);
      chk("t5_no_wr", 32'(bus.o_wr_ram), 32'd0);
      chk("t5_idle", 32'(bus.o_busy), 32'd0);
    end

    // 2048 NOPs, PC wraps, HLT found at address 0
    seq_q.delete();
    for (int i = 0; i < 2048; i++) begin
      prog[i] = 16'h4000 | 16'(i);
      seq_q.push_back(16'h4000 | 16'(i));
    end
    seq_q.push_back(16'h0042);
    start_run("wrap", 1'b1);
    goto(5);
    prog[0] = 16'h0042;
    drain();
    chk("t6_icount", 32'(bus.o_icount), 32'd2048);
    chk("t6_pc", 32'(bus.o_pc), 32'd0);
    chk("t6_halt", 32'(bus.o_halt), 32'd1);
    chk("t6_addr", 32'(bus.o_addr), 32'h042);

    // Restart from HALT
    seq_q = '{16'h0042};
    start_run("restart", 1'b1);
    chk("t6_re_pc", 32'(bus.o_pc), 32'd0);
    chk("t6_re_icount", 32'(bus.o_icount), 32'd0);
    chk("t6_re_busy", 32'(bus.o_busy), 32'd1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bip_control_unit.md
Name: bip_control_unit

Overview:
- Multi-cycle control unit for the 16-bit accumulator datapath (accumulator + ALU + data RAM).
- Fetches 16-bit instructions from a synchronous program memory and decodes them.
- Drives the accumulator input-mux selects, the accumulator enable, the ALU operation and the data-RAM read/write strobes.
- Maintains the PC and a retired-instruction counter for the debug unit; runs from an i_start pulse until HLT.

Parameters:
PC_BITS, 11, program counter / RAM address width
E_BITS, 16, instruction and data word width
OPC_BITS, 5, opcode field width (instr[15:11])

Ports:
i_clock  in  1  system clock; all state changes on rising edge
i_reset  in  1  synchronous, active-high reset
i_start  in  1  run request, sampled in IDLE or HALT only
i_instr  in  E_BITS  program-memory read data, valid one cycle after o_pc is presented
o_pc  out  PC_BITS  program-memory address
o_addr  out  PC_BITS  data-RAM address = IR[10:0]
o_operand  out  E_BITS  IR[10:0] sign-extended to E_BITS
o_sel_a  out  2  accumulator mux: 00 data RAM, 01 immediate, 10 ALU result
o_sel_b  out  1  ALU B operand: 0 data RAM, 1 immediate
o_op  out  1  ALU op: 0 add, 1 subtract
o_en_acc  out  1  accumulator load enable
o_rd_ram  out  1  data-RAM read strobe
o_wr_ram  out  1  data-RAM write strobe (accumulator -> RAM[o_addr])
o_busy  out  1  high in FETCH/LOAD/READ/EXEC
o_halt  out  1  high in HALT
o_icount  out  16  retired-instruction count, saturating

Behaviour:
- Reset: state=IDLE, PC=0, IR=0, icount=0; all strobes, o_busy and o_halt = 0; o_sel_a=00, o_sel_b=0, o_op=0.
- States: IDLE, FETCH, LOAD, READ, EXEC, HALT.
- Outputs are Moore functions of state and IR only; there is no combinational path from i_instr to any output.
- IDLE --i_start--> FETCH; at that transition PC=0 and icount=0.
- HALT --i_start--> FETCH; same PC/icount clear.
- HALT holds o_halt=1 and o_busy=0 while i_start=0.
- i_start is ignored while o_busy=1.
- FETCH: o_pc=PC. Next state is LOAD.
- LOAD: IR <= i_instr at the end of the cycle. Next state is HALT if i_instr[15:11]=00000, else READ.
- READ: o_rd_ram=1 only for LD, ADD, SUB. Next state is EXEC.
- EXEC: one-cycle strobes per opcode:
  - STO 00001: o_wr_ram=1.
  - LD 00010: sel_a=00, en_acc=1.
  - LDI 00011: sel_a=01, en_acc=1.
  - ADD 00100: sel_a=10, sel_b=0, op=0, en_acc=1.
  - ADDI 00101: sel_a=10, sel_b=1, op=0, en_acc=1.
  - SUB 00110: sel_a=10, sel_b=0, op=1, en_acc=1.
  - SUBI 00111: sel_a=10, sel_b=1, op=1, en_acc=1.
  - Opcodes 01000..11111: NOP, no strobes.
- EXEC exit: PC <= PC+1 (wraps 2047 -> 0); icount += 1 (saturates at 0xFFFF); next state is FETCH.
- Strobes (en_acc, rd_ram, wr_ram) are 0 in every state other than those listed above. sel/op hold 0 outside EXEC.
- Latency: every non-HLT instruction takes exactly 4 cycles. HLT takes 2 cycles (FETCH, LOAD), then HALT; it is not counted in icount and does not advance PC.
- o_addr and o_operand follow IR at all times.
- Reset mid-operation: if i_reset is high at a rising edge, all state returns to reset values at that edge. Any write scheduled for a later EXEC is never issued.

Test Plan:
- Reset, pulse i_start, program {LDI 5, ADDI 3, STO 7, HLT} -> expected response:
  - en_acc high in cycles 4 and 8 (cycle 1 = first FETCH), with sel_a=01 and sel_a=10/sel_b=1 respectively.
  - wr_ram high in cycle 12 with o_addr=7.
  - o_pc=3 in cycle 13; o_halt=1 from cycle 15; PC=3; icount=3.
- LD 0x010 -> rd_ram=1 in READ with o_addr=0x010; EXEC has sel_a=00, en_acc=1; rd_ram=0 in EXEC.
- SUBI with operand field 0x7FF -> o_operand=0xFFFF, op=1, sel_b=1, sel_a=10, en_acc=1 for exactly one cycle.
- Opcode 11111 followed by HLT -> no strobes at any point, HLT fetched at o_pc=1, icount=1; i_start pulsed during FETCH/LOAD/READ/EXEC has no effect.
- Reset asserted during READ of STO 0x005 -> wr_ram never asserted; next cycle state IDLE, PC=0, icount=0, o_busy=0.
- 2048 NOPs then HLT at address 0 after wrap -> PC wraps 2047 -> 0, halt reached, icount=2048; i_start in HALT restarts at o_pc=0 with icount=0.
